// File: rtl/axis2bram_multibuffer.sv
// AXI-Stream frame capture into NUM_BUFFERS round-robin BRAM banks.
// A bank stays occupied until the consumer releases it; over-long frames are truncated and flagged.
module axis2bram_multibuffer #(
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int BRAM_DATA_WIDTH = 32,
    parameter int BRAM_ADDR_WIDTH = 4,
    parameter int NUM_BUFFERS     = 2,
    localparam int IDX_W          = (NUM_BUFFERS > 1) ? $clog2(NUM_BUFFERS) : 1
) (
    input  logic                             ACC_CLK,
    input  logic                             ARESET,
    input  logic                             CTRL_ALLOW,
    input  logic                             CTRL_RELEASE,
    input  logic [IDX_W-1:0]                 CTRL_RELEASE_IDX,
    output logic                             CTRL_FINISHED,
    output logic [IDX_W-1:0]                 CTRL_BUF_IDX,
    output logic                             OVERFLOW,
    output logic [NUM_BUFFERS-1:0]           BUF_FULL,
    input  logic                             AXIS_TVALID,
    input  logic                             AXIS_TLAST,
    input  logic [AXIS_DATA_WIDTH-1:0]       AXIS_TDATA,
    output logic                             AXIS_TREADY,
    output logic [IDX_W+BRAM_ADDR_WIDTH-1:0] BRAM_ADDR,
    output logic [BRAM_DATA_WIDTH/8-1:0]     BRAM_WREN,
    output logic [BRAM_DATA_WIDTH-1:0]       BRAM_DOUT,
    output logic [31:0]                      DATA_DEPTH,
    output logic [31:0]                      FRAME_COUNT
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [BRAM_ADDR_WIDTH-1:0] ADDR_LAST = '1;
    localparam logic [BRAM_ADDR_WIDTH:0]   DEPTH_CNT = {1'b1, {BRAM_ADDR_WIDTH{1'b0}}};
    localparam logic [IDX_W-1:0]           IDX_LAST  = IDX_W'(NUM_BUFFERS - 1);

    state_t                     state_q, state_d;
    logic [IDX_W-1:0]           wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0]           buf_idx_q, buf_idx_d;
    logic [BRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [NUM_BUFFERS-1:0]     buf_full_q, buf_full_d;
    logic [NUM_BUFFERS-1:0]     rel_hit, set_hit;
    logic                       finished_q, finished_d;
    logic                       overflow_q, overflow_d;
    logic [BRAM_ADDR_WIDTH:0]   depth_q, depth_d;
    logic [31:0]                frame_count_q, frame_count_d;
    logic                       beat, finish, fin_ovf;
    logic [BRAM_ADDR_WIDTH:0]   fin_count;

    assign AXIS_TREADY = (state_q != IDLE);
    assign beat        = AXIS_TVALID && AXIS_TREADY;

    // Per-bank release/occupy decode; out-of-range release indices match no bank.
    generate
        for (genvar gi = 0; gi < NUM_BUFFERS; gi++) begin : g_bank
            assign rel_hit[gi] = CTRL_RELEASE && (CTRL_RELEASE_IDX == IDX_W'(gi));
            assign set_hit[gi] = finish && (wr_idx_q == IDX_W'(gi));
        end
    endgenerate

    // Completion set is applied after the release clear so it wins on a collision.
    assign buf_full_d = (buf_full_q & ~rel_hit) | set_hit;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wr_idx_d      = wr_idx_q;
        buf_idx_d     = buf_idx_q;
        overflow_d    = overflow_q;
        depth_d       = depth_q;
        frame_count_d = frame_count_q;
        finished_d    = 1'b0;
        finish        = 1'b0;
        fin_count     = '0;
        fin_ovf       = 1'b0;

        case (state_q)
            IDLE: begin
                if (CTRL_ALLOW && !buf_full_q[wr_idx_q]) begin
                    state_d = RUN;
                    addr_d  = '0;
                end
            end
            RUN: begin
                if (beat) begin
                    if (AXIS_TLAST) begin
                        finish    = 1'b1;
                        fin_count = {1'b0, addr_q} + 1'b1;
                    end else if (addr_q == ADDR_LAST) begin
                        state_d = DRAIN;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (beat && AXIS_TLAST) begin
                    finish    = 1'b1;
                    fin_count = DEPTH_CNT;
                    fin_ovf   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (finish) begin
            state_d       = IDLE;
            buf_idx_d     = wr_idx_q;
            depth_d       = fin_count;
            overflow_d    = fin_ovf;
            frame_count_d = frame_count_q + 32'd1;
            finished_d    = 1'b1;
            wr_idx_d      = (wr_idx_q == IDX_LAST) ? '0 : wr_idx_q + 1'b1;
        end
    end

    always_ff @(posedge ACC_CLK or posedge ARESET) begin
        if (ARESET) begin
            state_q       <= IDLE;
            wr_idx_q      <= '0;
            addr_q        <= '0;
            buf_full_q    <= '0;
            buf_idx_q     <= '0;
            finished_q    <= 1'b0;
            overflow_q    <= 1'b0;
            depth_q       <= '0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            wr_idx_q      <= wr_idx_d;
            addr_q        <= addr_d;
            buf_full_q    <= buf_full_d;
            buf_idx_q     <= buf_idx_d;
            finished_q    <= finished_d;
            overflow_q    <= overflow_d;
            depth_q       <= depth_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign BRAM_ADDR     = {wr_idx_q, addr_q};
    assign BRAM_WREN     = {(BRAM_DATA_WIDTH/8){AXIS_TVALID && (state_q == RUN)}};
    assign BRAM_DOUT     = AXIS_TDATA;
    assign CTRL_FINISHED = finished_q;
    assign CTRL_BUF_IDX  = buf_idx_q;
    assign OVERFLOW      = overflow_q;
    assign BUF_FULL      = buf_full_q;
    assign DATA_DEPTH    = {{(31 - BRAM_ADDR_WIDTH){1'b0}}, depth_q};
    assign FRAME_COUNT   = frame_count_q;

endmodule
